// File: rtl/alu_operand_serializer_pkg.sv
// Shared constants and state encoding for the ALU-side bit-serial operand/result adapter.
package alu_operand_serializer_pkg;

    localparam int DEF_REG_BITS = 8;
    localparam int DEF_NSHIFT   = 2;
    localparam int BEATS_SINGLE = DEF_REG_BITS / DEF_NSHIFT;
    localparam int BEATS_PAIR   = 2 * DEF_REG_BITS / DEF_NSHIFT;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_LOADED   = 2'd1,
        ST_SHIFTING = 2'd2
    } state_t;

    function automatic int beat_bits(input int reg_bits, input int nshift);
        return $clog2(2 * reg_bits / nshift);
    endfunction

endpackage

// File: rtl/alu_operand_serializer_if.sv
// Upstream operand handshake, ALU serial lanes and collected-result bus of the serializer.
interface alu_operand_serializer_if #(
    parameter int REG_BITS  = alu_operand_serializer_pkg::DEF_REG_BITS,
    parameter int NSHIFT    = alu_operand_serializer_pkg::DEF_NSHIFT,
    parameter int BEAT_BITS = $clog2(2 * REG_BITS / NSHIFT)
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [2*REG_BITS-1:0] in_data;
    logic                  in_pair;
    logic                  alu_active;
    logic                  alu_op_done;
    logic [NSHIFT-1:0]     alu_data_out;
    logic [NSHIFT-1:0]     data_in2;
    logic                  out_valid;
    logic [2*REG_BITS-1:0] out_data;
    logic [BEAT_BITS:0]    out_beats;
    logic                  underrun;

    modport master (
        output in_valid, in_data, in_pair, alu_active, alu_op_done, alu_data_out,
        input  in_ready, data_in2, out_valid, out_data, out_beats, underrun
    );

    modport slave (
        input  in_valid, in_data, in_pair, alu_active, alu_op_done, alu_data_out,
        output in_ready, data_in2, out_valid, out_data, out_beats, underrun
    );

endinterface

// File: rtl/alu_operand_serializer_serial_shift_reg.sv
// Right-shifting register, STEP bits per enabled cycle, new bits entering at the MSB end.
module serial_shift_reg #(
    parameter int WIDTH = 16,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift_en,
    input  logic [STEP-1:0]  shift_in,
    output logic [WIDTH-1:0] q
);

    // Load beats shift so a new operand can land in the same cycle the last beat leaves.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (shift_en)
            q <= {shift_in, q[WIDTH-1:STEP]};
    end

endmodule

// File: rtl/alu_operand_serializer.sv
// Bit-serial operand feeder and result collector beside the ALU: parallel in, NSHIFT bits per cycle.
module alu_operand_serializer
    import alu_operand_serializer_pkg::*;
#(
    parameter int REG_BITS  = DEF_REG_BITS,
    parameter int NSHIFT    = DEF_NSHIFT,
    parameter int BEAT_BITS = $clog2(2 * REG_BITS / NSHIFT)
) (
    input  logic                    clk,
    input  logic                    reset,
    alu_operand_serializer_if.slave bus
);

    localparam int W     = 2 * REG_BITS;
    localparam int TOTAL = W / NSHIFT;
    localparam int BW    = BEAT_BITS + 1;

    state_t          state;
    logic [BW-1:0]   beats;
    logic [BW-1:0]   beats_next;
    logic [W-1:0]    operand;
    logic [W-1:0]    capture;
    logic [W-1:0]    capture_next;
    logic [W-1:0]    load_val;
    logic [W-1:0]    aligned;
    logic            ready;
    logic            load;
    logic            op_shift;
    logic            done;
    int              pad;

    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [BW-1:0]   out_beats;
    logic            underrun;

    // Accepting in the done cycle lets the next operand start with no bubble beat.
    assign ready    = (state == ST_EMPTY) ||
                      (state == ST_SHIFTING && bus.alu_active && bus.alu_op_done);
    assign load     = bus.in_valid && ready;
    assign load_val = bus.in_pair ? bus.in_data
                                  : {{REG_BITS{1'b0}}, bus.in_data[REG_BITS-1:0]};
    assign op_shift = bus.alu_active && (state != ST_EMPTY);
    assign done     = bus.alu_active && bus.alu_op_done;

    assign capture_next = {bus.alu_data_out, capture[W-1:NSHIFT]};
    assign beats_next   = beats + BW'(1);

    // Short ops leave their bits at the top of the collector; slide them down to bit 0.
    always_comb begin
        pad = 0;
        if (int'(beats_next) < TOTAL)
            pad = (TOTAL - int'(beats_next)) * NSHIFT;
        aligned = capture_next >> pad;
    end

    serial_shift_reg #(.WIDTH(W), .STEP(NSHIFT)) u_operand (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .shift_en (op_shift),
        .shift_in ({NSHIFT{1'b0}}),
        .q        (operand)
    );

    // The collector runs on every active cycle, even with no operand, so ALU results stay visible.
    serial_shift_reg #(.WIDTH(W), .STEP(NSHIFT)) u_capture (
        .clk      (clk),
        .reset    (reset),
        .load     (1'b0),
        .load_val ({W{1'b0}}),
        .shift_en (bus.alu_active),
        .shift_in (bus.alu_data_out),
        .q        (capture)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            beats     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            underrun  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (bus.alu_active) begin
                beats <= beats_next;
                if (state == ST_EMPTY)
                    underrun <= 1'b1;
                else
                    state <= ST_SHIFTING;
                if (done) begin
                    out_valid <= 1'b1;
                    out_data  <= aligned;
                    out_beats <= beats_next;
                    beats     <= '0;
                    state     <= ST_EMPTY;
                end
            end
            // A fresh operand always starts a fresh beat count.
            if (load) begin
                state <= ST_LOADED;
                beats <= '0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.data_in2  = (state == ST_EMPTY) ? '0 : operand[NSHIFT-1:0];
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_beats = out_beats;
    assign bus.underrun  = underrun;

    a_beats_nonzero: assert property (@(posedge clk) disable iff (reset)
        out_valid |-> (out_beats != '0));

    a_hold_when_idle: assert property (@(posedge clk) disable iff (reset)
        (state == ST_LOADED && !bus.alu_active) |=> $stable(operand));

endmodule

// File: tb/tb_alu_operand_serializer.sv
// Scenario bench for alu_operand_serializer: per-beat data_in2 checks plus a result scoreboard.
module tb_alu_operand_serializer;
    import alu_operand_serializer_pkg::*;

    localparam int RB = DEF_REG_BITS;
    localparam int NS = DEF_NSHIFT;
    localparam int W  = 2 * RB;
    localparam int BB = $clog2(W / NS);

    typedef struct {
        logic [W-1:0] data;
        logic [BB:0]  beats;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    alu_operand_serializer_if #(.REG_BITS(RB), .NSHIFT(NS)) bus();

    alu_operand_serializer #(.REG_BITS(RB), .NSHIFT(NS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Result monitor: every out_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_valid_unexpected: pulse with out_data=%h, none expected", bus.out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.out_data !== e.data) begin
                    n_fail++;
                    $display("FAIL out_data: got %h want %h", bus.out_data, e.data);
                end
                n_tests++;
                if (bus.out_beats !== e.beats) begin
                    n_fail++;
                    $display("FAIL out_beats: got %0d want %0d", bus.out_beats, e.beats);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid     = 1'b0;
        bus.alu_active   = 1'b0;
        bus.alu_op_done  = 1'b0;
        bus.alu_data_out = '0;
    endtask

    task automatic test_reset();
        idle();
        bus.in_data = '0;
        bus.in_pair = 1'b0;
        reset = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_tests++;
        if (bus.data_in2 !== 2'b00) begin n_fail++; $display("FAIL reset_data_in2: got %b want 00", bus.data_in2); end
        n_tests++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_tests++;
        if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
        n_tests++;
        if (bus.out_beats !== '0) begin n_fail++; $display("FAIL reset_out_beats: got %0d want 0", bus.out_beats); end
        n_tests++;
        if (bus.underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", bus.underrun); end
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_byte();
        logic [1:0]   d [4];
        logic [W-1:0] m;
        exp_t         e;
        d = '{2'b11, 2'b00, 2'b11, 2'b00};
        m = 16'h00A5;
        e.data = '0;
        for (int i = 0; i < 4; i++) e.data[2*i +: 2] = d[i];
        e.beats = 4;
        bus.in_valid = 1'b1; bus.in_data = 16'h00A5; bus.in_pair = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL byte_accept: in_ready %b want 1", bus.in_ready); end
        cyc();
        bus.in_valid = 1'b0; bus.in_data = 16'hFFFF; bus.in_pair = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            bus.alu_active = 1'b1; bus.alu_op_done = (i == 3); bus.alu_data_out = d[i];
            @(negedge clk);
            n_tests++;
            if (bus.data_in2 !== m[2*i +: 2]) begin
                n_fail++; $display("FAIL byte_data_in2[%0d]: got %b want %b", i, bus.data_in2, m[2*i +: 2]);
            end
            cyc();
        end
        idle();
        @(negedge clk);
        cyc();
    endtask

    task automatic test_pair();
        logic [W-1:0] m;
        exp_t         e;
        m = 16'h1234;
        e.data = m; e.beats = 8;
        bus.in_valid = 1'b1; bus.in_data = m; bus.in_pair = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            bus.alu_active = 1'b1; bus.alu_op_done = (i == 7); bus.alu_data_out = m[2*i +: 2];
            @(negedge clk);
            n_tests++;
            if (bus.data_in2 !== m[2*i +: 2]) begin
                n_fail++; $display("FAIL pair_data_in2[%0d]: got %b want %b", i, bus.data_in2, m[2*i +: 2]);
            end
            cyc();
        end
        idle();
        @(negedge clk);
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] m2;
        exp_t         e;
        m2 = 16'h0001;
        bus.in_valid = 1'b1; bus.in_data = 16'h00FF; bus.in_pair = 1'b0;
        cyc();
        bus.in_data = m2;
        e.data = 16'h00AA; e.beats = 4;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            bus.alu_active = 1'b1; bus.alu_op_done = (i == 3); bus.alu_data_out = 2'b10;
            @(negedge clk);
            n_tests++;
            if (bus.data_in2 !== 2'b11) begin
                n_fail++; $display("FAIL b2b_op1_data_in2[%0d]: got %b want 11", i, bus.data_in2);
            end
            n_tests++;
            if (bus.in_ready !== (i == 3)) begin
                n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want %b", i, bus.in_ready, (i == 3));
            end
            cyc();
        end
        bus.in_valid = 1'b0;
        e.data = 16'h0055; e.beats = 4;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            bus.alu_active = 1'b1; bus.alu_op_done = (i == 3); bus.alu_data_out = 2'b01;
            @(negedge clk);
            n_tests++;
            if (bus.data_in2 !== m2[2*i +: 2]) begin
                n_fail++; $display("FAIL b2b_op2_data_in2[%0d]: got %b want %b", i, bus.data_in2, m2[2*i +: 2]);
            end
            cyc();
        end
        idle();
        @(negedge clk);
        cyc();
    endtask

    task automatic test_rotate();
        logic [1:0]   d [3];
        logic [W-1:0] m;
        exp_t         e;
        d = '{2'b01, 2'b10, 2'b11};
        e.data = '0;
        for (int i = 0; i < 3; i++) e.data[2*i +: 2] = d[i];
        e.beats = 3;
        bus.in_valid = 1'b1; bus.in_data = 16'hFFFF; bus.in_pair = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < 3; i++) begin
            bus.alu_active = 1'b1; bus.alu_op_done = (i == 2); bus.alu_data_out = d[i];
            @(negedge clk);
            n_tests++;
            if (bus.data_in2 !== 2'b11) begin
                n_fail++; $display("FAIL rot_data_in2[%0d]: got %b want 11", i, bus.data_in2);
            end
            cyc();
        end
        idle();
        m = 16'h00C3;
        bus.in_valid = 1'b1; bus.in_data = m; bus.in_pair = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rot_ready_after: got %b want 1", bus.in_ready); end
        cyc();
        bus.in_valid = 1'b0;
        e.data = '0; e.beats = 4;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            bus.alu_active = 1'b1; bus.alu_op_done = (i == 3); bus.alu_data_out = 2'b00;
            @(negedge clk);
            n_tests++;
            if (bus.data_in2 !== m[2*i +: 2]) begin
                n_fail++; $display("FAIL rot_next_data_in2[%0d]: got %b want %b", i, bus.data_in2, m[2*i +: 2]);
            end
            cyc();
        end
        idle();
        @(negedge clk);
        cyc();
    endtask

    task automatic test_underrun();
        logic [W-1:0] m;
        exp_t         e;
        m = 16'h0003;
        for (int i = 0; i < 2; i++) begin
            bus.alu_active = 1'b1; bus.alu_op_done = 1'b0; bus.alu_data_out = 2'b11;
            @(negedge clk);
            n_tests++;
            if (bus.data_in2 !== 2'b00) begin
                n_fail++; $display("FAIL under_data_in2[%0d]: got %b want 00", i, bus.data_in2);
            end
            cyc();
        end
        idle();
        bus.in_valid = 1'b1; bus.in_data = m; bus.in_pair = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.underrun !== 1'b1) begin n_fail++; $display("FAIL under_set: got %b want 1", bus.underrun); end
        cyc();
        bus.in_valid = 1'b0;
        e.data = 16'h0055; e.beats = 4;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            bus.alu_active = 1'b1; bus.alu_op_done = (i == 3); bus.alu_data_out = 2'b01;
            @(negedge clk);
            n_tests++;
            if (bus.data_in2 !== m[2*i +: 2]) begin
                n_fail++; $display("FAIL under_op_data_in2[%0d]: got %b want %b", i, bus.data_in2, m[2*i +: 2]);
            end
            cyc();
        end
        idle();
        @(negedge clk);
        n_tests++;
        if (bus.underrun !== 1'b1) begin n_fail++; $display("FAIL under_sticky: got %b want 1", bus.underrun); end
        cyc();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] m;
        m = 16'h00A5;
        bus.in_valid = 1'b1; bus.in_data = m; bus.in_pair = 1'b0;
        cyc();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.alu_active = 1'b1; bus.alu_op_done = 1'b0; bus.alu_data_out = 2'b10;
            @(negedge clk);
            n_tests++;
            if (bus.data_in2 !== m[2*i +: 2]) begin
                n_fail++; $display("FAIL rstmid_data_in2[%0d]: got %b want %b", i, bus.data_in2, m[2*i +: 2]);
            end
            cyc();
        end
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
        n_tests++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
        n_tests++;
        if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL rstmid_out_data: got %h want 0000", bus.out_data); end
        n_tests++;
        if (bus.underrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_underrun: got %b want 0", bus.underrun); end
        n_tests++;
        if (bus.data_in2 !== 2'b00) begin n_fail++; $display("FAIL rstmid_data_in2: got %b want 00", bus.data_in2); end
        repeat (2) cyc();
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_pulse: got %b want 0", bus.out_valid); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_byte();
        test_pair();
        test_back_to_back();
        test_rotate();
        test_underrun();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results never produced, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
